sata_rx_prim_decode: RTL and testbench
======================================

Name: sata_rx_prim_decode

Overview:
Receive-side stage directly downstream of the SATA PHY wrapper. It consumes the per-port 32-bit rxdata/rxdatak stream in the phyclk domain and classifies each dword as a primitive, frame data or junk. It drops ALIGN dwords and expands CONT-suppressed primitive runs. It delivers a clean primitive code stream and in-frame data with valid strobes to the link-layer state machine, with error flagging.

Parameters:
C_ERRCNT_W, 8, width of the saturating error counter.

Ports:
phyclk  in  1  PHY-side user clock; all logic on its rising edge.
phyreset  in  1  synchronous, active-high reset.
linkup  in  1  PHY link-up; low acts as synchronous soft reset of decode state.
rxdata  in  32  received dword, byte 0 in [7:0].
rxdatak  in  1  dword is a primitive (K28.x in byte 0).
data_out  out  32  registered frame data dword.
data_vld  out  1  data_out valid, one cycle.
prim_code  out  5  current primitive code; held between updates.
prim_vld  out  1  prim_code valid this cycle, including CONT-repeated cycles.
in_frame  out  1  between SOF and frame end.
cont_active  out  1  CONT suppression in progress.
prim_err  out  1  one-cycle error pulse.
err_cnt  out  C_ERRCNT_W  saturating error count.

Behaviour:
- Reset (phyreset=1): all outputs 0; state NORMAL; last_prim=NONE; in_frame=0; err_cnt=0.
- All outputs are registered. Latency is 1 cycle from an input dword to its classification.
- Primitive codes (match on full 32 bits, rxdatak=1):
  - 0 NONE
  - 1 SYNC B5B5957C, 2 X_RDY 5757B57C, 3 R_RDY 4A4A957C, 4 SOF 3737B57C
  - 5 EOF D5D5B57C, 6 HOLD D5D5AA7C, 7 HOLDA 9595AA7C, 8 WTRM 5858B57C
  - 9 R_IP 5555B57C, 10 R_OK 3535B57C, 11 R_ERR 5656B57C, 12 DMAT 3636B57C
  - 13 PMREQ_P 1717B57C, 14 PMREQ_S 7575957C, 15 PMACK 9595957C, 16 PMNAK F5F5957C
  - 31 UNKNOWN
  - Special, no code: ALIGN 7B4A4ABC, CONT 9999AA7C.
- linkup=0: same effect as reset except err_cnt is retained; the input is ignored.
- Per-dword rules, with linkup=1. All cases not listed produce prim_vld=0 and data_vld=0.
- ALIGN: dropped; no output strobes; state, last_prim, in_frame and cont_active unchanged. This holds during CONT too.
- Known primitive P (codes 1-16):
  - prim_vld=1, prim_code=P, last_prim=P; state goes to NORMAL; cont_active=0.
  - SOF sets in_frame=1; a SOF while already in_frame restarts the frame with no error.
  - EOF, SYNC or WTRM clear in_frame.
  - HOLD, HOLDA and the others leave in_frame unchanged.
  - in_frame updates on the same edge as prim_vld.
- CONT:
  - In NORMAL with last_prim!=NONE: state goes to CONT; cont_active=1; prim_vld=1; prim_code=last_prim.
  - In NORMAL with last_prim=NONE: prim_err pulse; stay NORMAL.
  - In CONT: prim_vld=1 with last_prim; stays CONT.
- Unknown K dword: prim_code=31, prim_vld=1, prim_err pulse, last_prim=NONE, state goes to NORMAL, cont_active=0.
- Non-K dword in CONT: treated as scrambled junk. prim_vld=1, prim_code=last_prim, data_vld=0, no error.
- Non-K dword in NORMAL:
  - If in_frame=1: data_out=rxdata, data_vld=1; prim_code holds its old value with prim_vld=0.
  - If in_frame=0: dropped, with a prim_err pulse.
- err_cnt increments on each prim_err and saturates at all-ones; only phyreset clears it.
- data_out is held when data_vld=0.

Test Plan:
- Reset, then linkup=1, then SYNC x3 → prim_vld=1 three cycles, prim_code=1; all other outputs 0.
- Sequence X_RDY, X_RDY, CONT, 5 junk dwords (rxdatak=0), ALIGN, ALIGN, R_IP:
  - prim_code=2 for 8 valid cycles; cont_active=1 over CONT+junk; no data_vld.
  - ALIGN cycles have no strobes; then prim_code=9, cont_active=0.
- Frame: SOF, data 0x11223344, 0xAABBCCDD, HOLD, HOLD, CONT, junk x2, HOLD, data 0x55667788, EOF:
  - in_frame=1 from the SOF output cycle.
  - data_vld exactly 3 times with those values; junk never appears on data_out.
  - in_frame=0 after EOF.
- Errors: data 0xDEADBEEF outside frame, CONT after reset, K dword 0x12345678:
  - three prim_err pulses; prim_code=31 on the last; err_cnt=3.
- Drive 300 unknown K dwords → err_cnt saturates at 255. Then deassert linkup for 1 cycle mid-frame → in_frame=0, cont_active=0, err_cnt stays 255.
- Assert phyreset during a CONT run → next cycle all outputs 0, err_cnt=0. Junk after reset release raises prim_err, since it is outside a frame.

Source files
------------

// File: rtl/sata_rx_prim_decode.sv
// Receive primitive decoder: classifies PHY dwords as primitives, frame data or junk,
// drops ALIGN, expands CONT runs and flags protocol errors.
module sata_rx_prim_decode #(
    parameter int C_ERRCNT_W = 8
) (
    input  logic                  phyclk,
    input  logic                  phyreset,
    input  logic                  linkup,
    input  logic [31:0]           rxdata,
    input  logic                  rxdatak,
    output logic [31:0]           data_out,
    output logic                  data_vld,
    output logic [4:0]            prim_code,
    output logic                  prim_vld,
    output logic                  in_frame,
    output logic                  cont_active,
    output logic                  prim_err,
    output logic [C_ERRCNT_W-1:0] err_cnt
);

    localparam logic [31:0] DW_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] DW_CONT  = 32'h9999AA7C;

    localparam logic [4:0] CODE_NONE    = 5'd0;
    localparam logic [4:0] CODE_SYNC    = 5'd1;
    localparam logic [4:0] CODE_SOF     = 5'd4;
    localparam logic [4:0] CODE_EOF     = 5'd5;
    localparam logic [4:0] CODE_WTRM    = 5'd8;
    localparam logic [4:0] CODE_UNKNOWN = 5'd31;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_CONT   = 1'b1
    } state_t;

    function automatic logic [4:0] lookup_prim(input logic [31:0] dw);
        case (dw)
            32'hB5B5957C: lookup_prim = 5'd1;
            32'h5757B57C: lookup_prim = 5'd2;
            32'h4A4A957C: lookup_prim = 5'd3;
            32'h3737B57C: lookup_prim = 5'd4;
            32'hD5D5B57C: lookup_prim = 5'd5;
            32'hD5D5AA7C: lookup_prim = 5'd6;
            32'h9595AA7C: lookup_prim = 5'd7;
            32'h5858B57C: lookup_prim = 5'd8;
            32'h5555B57C: lookup_prim = 5'd9;
            32'h3535B57C: lookup_prim = 5'd10;
            32'h5656B57C: lookup_prim = 5'd11;
            32'h3636B57C: lookup_prim = 5'd12;
            32'h1717B57C: lookup_prim = 5'd13;
            32'h7575957C: lookup_prim = 5'd14;
            32'h9595957C: lookup_prim = 5'd15;
            32'hF5F5957C: lookup_prim = 5'd16;
            default:      lookup_prim = CODE_UNKNOWN;
        endcase
    endfunction

    state_t                  state, state_d;
    logic [4:0]              last_prim, last_prim_d;
    logic [4:0]              known_code;
    logic                    in_frame_d, data_vld_d, prim_vld_d, prim_err_d;
    logic [4:0]              prim_code_d;
    logic [31:0]             data_out_d;
    logic [C_ERRCNT_W-1:0]   err_cnt_d;

    assign known_code = lookup_prim(rxdata);

    // NOTE: every variable gets its hold value first so no path through the
    // case tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        last_prim_d = last_prim;
        in_frame_d  = in_frame;
        data_out_d  = data_out;
        prim_code_d = prim_code;
        data_vld_d  = 1'b0;
        prim_vld_d  = 1'b0;
        prim_err_d  = 1'b0;

        if (!linkup) begin
            state_d     = ST_NORMAL;
            last_prim_d = CODE_NONE;
            in_frame_d  = 1'b0;
            data_out_d  = '0;
            prim_code_d = CODE_NONE;
        end else if (rxdatak && rxdata == DW_ALIGN) begin
            // ALIGN is transparent: nothing changes, not even CONT expansion
        end else if (rxdatak && rxdata == DW_CONT) begin
            if (state == ST_CONT || last_prim != CODE_NONE) begin
                state_d     = ST_CONT;
                prim_vld_d  = 1'b1;
                prim_code_d = last_prim;
            end else begin
                prim_err_d = 1'b1;
            end
        end else if (rxdatak) begin
            state_d     = ST_NORMAL;
            prim_vld_d  = 1'b1;
            prim_code_d = known_code;
            if (known_code == CODE_UNKNOWN) begin
                prim_err_d  = 1'b1;
                last_prim_d = CODE_NONE;
            end else begin
                last_prim_d = known_code;
                if (known_code == CODE_SOF)
                    in_frame_d = 1'b1;
                else if (known_code == CODE_EOF || known_code == CODE_SYNC ||
                         known_code == CODE_WTRM)
                    in_frame_d = 1'b0;
            end
        end else if (state == ST_CONT) begin
            prim_vld_d  = 1'b1;
            prim_code_d = last_prim;
        end else if (in_frame) begin
            data_out_d = rxdata;
            data_vld_d = 1'b1;
        end else begin
            prim_err_d = 1'b1;
        end

        err_cnt_d = err_cnt;
        if (prim_err_d && err_cnt != '1)
            err_cnt_d = err_cnt + 1'b1;
    end

    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            state     <= ST_NORMAL;
            last_prim <= CODE_NONE;
            in_frame  <= 1'b0;
            data_out  <= '0;
            data_vld  <= 1'b0;
            prim_code <= CODE_NONE;
            prim_vld  <= 1'b0;
            prim_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            last_prim <= last_prim_d;
            in_frame  <= in_frame_d;
            data_out  <= data_out_d;
            data_vld  <= data_vld_d;
            prim_code <= prim_code_d;
            prim_vld  <= prim_vld_d;
            prim_err  <= prim_err_d;
            err_cnt   <= err_cnt_d;
        end
    end

    assign cont_active = (state == ST_CONT);

endmodule

// File: tb/tb_sata_rx_prim_decode.sv
// Self-checking bench for sata_rx_prim_decode: directed test-plan sequences plus
// randomized dwords, all compared against a table-driven behavioural model.
module tb_sata_rx_prim_decode;

    localparam int ERRW = 8;
    localparam int CNT_MAX = (1 << ERRW) - 1;

    logic            phyclk = 1'b0;
    logic            phyreset, linkup, rxdatak;
    logic [31:0]     rxdata;
    logic [31:0]     data_out;
    logic            data_vld, prim_vld, in_frame, cont_active, prim_err;
    logic [4:0]      prim_code;
    logic [ERRW-1:0] err_cnt;

    sata_rx_prim_decode #(.C_ERRCNT_W(ERRW)) dut (
        .phyclk(phyclk), .phyreset(phyreset), .linkup(linkup),
        .rxdata(rxdata), .rxdatak(rxdatak),
        .data_out(data_out), .data_vld(data_vld),
        .prim_code(prim_code), .prim_vld(prim_vld),
        .in_frame(in_frame), .cont_active(cont_active),
        .prim_err(prim_err), .err_cnt(err_cnt)
    );

    always #5 phyclk = ~phyclk;

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] CONT  = 32'h9999AA7C;

    // Index = primitive code; entry 0 unused.
    logic [31:0] prim_tab [0:16] = '{32'h0,
        32'hB5B5957C, 32'h5757B57C, 32'h4A4A957C, 32'h3737B57C,
        32'hD5D5B57C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h5858B57C,
        32'h5555B57C, 32'h3535B57C, 32'h5656B57C, 32'h3636B57C,
        32'h1717B57C, 32'h7575957C, 32'h9595957C, 32'hF5F5957C};

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference state
    bit      m_cont, m_in_frame, m_dvld, m_pvld, m_err;
    int      m_last, m_code, m_cnt;
    logic [31:0] m_data;

    function automatic int code_of(input logic [31:0] d);
        for (int i = 1; i <= 16; i++)
            if (prim_tab[i] == d) return i;
        return 31;
    endfunction

    task automatic model_clear(input bit keep_cnt);
        m_cont = 0; m_in_frame = 0; m_dvld = 0; m_pvld = 0; m_err = 0;
        m_last = 0; m_code = 0; m_data = '0;
        if (!keep_cnt) m_cnt = 0;
    endtask

    task automatic model_step(input logic [31:0] d, input bit k, input bit lu, input bit rst);
        if (rst) begin
            model_clear(0);
            return;
        end
        if (!lu) begin
            model_clear(1);
            return;
        end
        m_dvld = 0; m_pvld = 0; m_err = 0;
        if (k && d == ALIGN) begin
        end else if (k && d == CONT) begin
            if (m_cont || m_last != 0) begin
                m_cont = 1; m_pvld = 1; m_code = m_last;
            end else m_err = 1;
        end else if (k) begin
            int p;
            p = code_of(d);
            m_pvld = 1; m_code = p; m_cont = 0;
            if (p == 31) begin
                m_err = 1; m_last = 0;
            end else begin
                m_last = p;
                if (p == 4) m_in_frame = 1;
                if (p == 1 || p == 5 || p == 8) m_in_frame = 0;
            end
        end else if (m_cont) begin
            m_pvld = 1; m_code = m_last;
        end else if (m_in_frame) begin
            m_data = d; m_dvld = 1;
        end else m_err = 1;
        if (m_err && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".data_out"},    data_out,            m_data);
        check({ctx, ".data_vld"},    32'(data_vld),       32'(m_dvld));
        check({ctx, ".prim_code"},   32'(prim_code),      32'(m_code));
        check({ctx, ".prim_vld"},    32'(prim_vld),       32'(m_pvld));
        check({ctx, ".in_frame"},    32'(in_frame),       32'(m_in_frame));
        check({ctx, ".cont_active"}, 32'(cont_active),    32'(m_cont));
        check({ctx, ".prim_err"},    32'(prim_err),       32'(m_err));
        check({ctx, ".err_cnt"},     32'(err_cnt),        32'(m_cnt));
    endtask

    // Drive one dword for one cycle, then compare every output with the model.
    task automatic step(input string ctx, input logic [31:0] d, input bit k,
                        input bit lu = 1'b1, input bit rst = 1'b0);
        @(negedge phyclk);
        rxdata = d; rxdatak = k; linkup = lu; phyreset = rst;
        @(posedge phyclk);
        model_step(d, k, lu, rst);
        #1;
        check_all(ctx);
    endtask

    task automatic prim(input string ctx, input int p);
        step(ctx, prim_tab[p], 1'b1);
    endtask

    task automatic junk(input string ctx);
        step(ctx, $urandom, 1'b0);
    endtask

    int dv_count;

    initial begin
        rxdata = '0; rxdatak = 0; linkup = 0; phyreset = 1;
        model_clear(0);
        step("reset0", 32'h0, 0, 0, 1);
        step("reset1", prim_tab[1], 1, 1, 1);

        // SYNC x3
        for (int i = 0; i < 3; i++) prim("sync", 1);
        check("sync.code_const", 32'(prim_code), 32'd1);

        // X_RDY x2, CONT, junk x5, ALIGN x2, R_IP
        prim("xrdy", 2); prim("xrdy", 2);
        step("cont", CONT, 1);
        check("cont.active_const", 32'(cont_active), 32'd1);
        for (int i = 0; i < 5; i++) junk("cont_junk");
        step("align_in_cont", ALIGN, 1);
        step("align_in_cont", ALIGN, 1);
        check("align.cont_held", 32'(cont_active), 32'd1);
        prim("rip", 9);
        check("rip.code_const", 32'(prim_code), 32'd9);

        // Frame with HOLD/CONT inside
        dv_count = 0;
        prim("sof", 4);
        check("sof.in_frame_const", 32'(in_frame), 32'd1);
        step("data1", 32'h11223344, 0); dv_count += int'(data_vld);
        step("data2", 32'hAABBCCDD, 0); dv_count += int'(data_vld);
        prim("hold", 6); prim("hold", 6);
        step("hold_cont", CONT, 1);
        junk("hold_junk"); junk("hold_junk");
        check("junk_not_data", data_out, 32'hAABBCCDD);
        prim("hold", 6);
        step("data3", 32'h55667788, 0); dv_count += int'(data_vld);
        check("data3.value_const", data_out, 32'h55667788);
        prim("eof", 5);
        check("frame.data_vld_count", 32'(dv_count), 32'd3);
        check("eof.in_frame_const", 32'(in_frame), 32'd0);

        // Error cases from a fresh reset
        step("err_reset", 32'h0, 0, 1, 1);
        step("err_data_outside", 32'hDEADBEEF, 0);
        step("err_cont_after_reset", CONT, 1);
        step("err_unknown_k", 32'h12345678, 1);
        check("err.code_const", 32'(prim_code), 32'd31);
        check("err.cnt_const", 32'(err_cnt), 32'd3);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) step("sat", 32'h12345678, 1);
        check("sat.cnt_const", 32'(err_cnt), 32'(CNT_MAX));

        // linkup drop mid-frame
        prim("lu_sof", 4);
        step("lu_data", 32'hCAFEF00D, 0);
        step("lu_drop", $urandom, 1, 0);
        check("lu.in_frame_const", 32'(in_frame), 32'd0);
        check("lu.cnt_kept_const", 32'(err_cnt), 32'(CNT_MAX));

        // phyreset in the middle of a CONT run
        prim("rst_xrdy", 2);
        step("rst_cont", CONT, 1);
        junk("rst_junk");
        step("rst_hit", $urandom, 0, 1, 1);
        check("rst.cnt_const", 32'(err_cnt), 32'd0);
        junk("post_rst_junk");
        check("post_rst.err_const", 32'(prim_err), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)       step("rnd_linkdown", $urandom, $urandom_range(0, 1), 0);
            else if (sel < 4)  step("rnd_reset", $urandom, $urandom_range(0, 1), 1, 1);
            else if (sel < 12) step("rnd_align", ALIGN, 1);
            else if (sel < 24) step("rnd_cont", CONT, 1);
            else if (sel < 30) step("rnd_unknown_k", $urandom, 1);
            else if (sel < 36) prim("rnd_sof", 4);
            else if (sel < 62) prim("rnd_prim", $urandom_range(1, 16));
            else               junk("rnd_nonk");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
